wasm_cpu_top: RTL and testbench
===============================

WASM_CPU_TOP -- requirements
Module: wasm_cpu_top

Interface
REQ-001 SHALL have parameter INSTR_DEPTH, default 512, instruction words stored (64-bit each).
REQ-002 SHALL have parameter STACK_DEPTH, default 16, operand stack entries (32-bit each).
REQ-003 SHALL have parameter OUT_DEPTH, default 256, output line-memory words (32-bit each); GLOBAL_NUM fixed at 16.
REQ-004 SHALL have the following ports; the clock and reset are fixed as: one clock; reset is asynchronous and active-low.
- i_clk  in  1  sole clock, rising edge.
- i_rst_n  in  1  async active-low reset.
- o_ERROR  out  3  trap code.
- o_work_state  out  2  00 LOAD, 01 EXEC, 10 TRAP, 11 DONE.
- o_instr_mem_wr_rdy  out  1  high in LOAD only.
- i_instr_mem_wr_vld  in  1  write strobe.
- i_instr_mem_wr_addr  in  15  word address; low log2(INSTR_DEPTH) bits used.
- i_instr_mem_wr_data  in  64  instruction word.
- i_instr_mem_wr_finish  in  1  program loaded.
- i_line_mem_rd_rdy  in  1  host read request.
- i_line_mem_rd_addr  in  9  bit8=1: global[addr[3:0]]; bit8=0: out_mem[addr[7:0]].
- o_line_mem_rd_data  out  32  read data.
- i_scl, i_sda  in  1 each  I2C debug bus.
- o_sda  out  1  open-drain SDA; 0 pulls low, 1 releases.
- i_debug_ena  in  1  debug request.

Function
REQ-005 SHALL, in LOAD, write i_instr_mem_wr_data to the addressed word on each rising edge with i_instr_mem_wr_vld=1.
REQ-006 SHALL move LOAD->EXEC on the edge i_instr_mem_wr_finish=1 (a same-cycle write still completes), with pc=0, sp=0; write strobes outside LOAD are ignored.
REQ-007 SHALL decode opcode=word[63:56], imm=word[31:0], and execute one instruction per cycle in EXEC, advancing pc by 1 unless branching.
REQ-008 SHALL implement: 0x01 nop; 0x0B end -> DONE; 0x0C br (pc=imm); 0x0D br_if (pop c, pc=imm if c!=0); 0x1A drop; 0x41 i32.const push imm; 0x23 global.get push g[imm[3:0]]; 0x24 global.set pop into g[imm[3:0]].
REQ-009 SHALL implement 0x28 i32.load (pop a, push out_mem[a[7:0]]) and 0x36 i32.store (pop v, pop a, out_mem[a[7:0]]=v).
REQ-010 SHALL implement binary ops popping b then a, pushing result: 0x46 eq, 0x48 lt_s, 0x6A add, 0x6B sub, 0x6C mul (low 32 bits), 0x71 and, 0x72 or, 0x73 xor, 0x74 shl, 0x75 shr_s, 0x76 shr_u; shift count = b[4:0]; compares push 1/0; 0x45 eqz unary.
REQ-011 SHALL use wrap-around 32-bit two's-complement arithmetic with no overflow trap.
REQ-012 SHALL trap to state 10 with o_ERROR: 001 pop on insufficient operands, 010 push at sp=STACK_DEPTH, 011 opcode 0x00, 100 undefined opcode, 101 pc>=INSTR_DEPTH; the trapping instruction has no side effects.
REQ-013 SHALL hold DONE and TRAP until reset; o_ERROR stays 000 except in TRAP.
REQ-014 SHALL, in any state, register o_line_mem_rd_data on each rising edge with i_line_mem_rd_rdy=1 (one-cycle latency), holding otherwise; unmapped addresses read 0.
REQ-015 SHALL stall EXEC (no pc/state change) while i_debug_ena=1.

Reset
REQ-016 SHALL on i_rst_n=0 asynchronously set state LOAD, pc=0, sp=0, o_ERROR=000, o_line_mem_rd_data=0, o_sda=1, globals and out_mem=0; instruction memory not cleared; reset mid-EXEC aborts to LOAD.

Configuration
REQ-017 SHALL, with DEBUG_I2C_EN defined, include an I2C read-only slave at 7-bit address 0x6C (i_scl/i_sda 2-flop synchronised to i_clk), active only while i_debug_ena=1: write sets register pointer, read returns 0x00 pc[7:0], 0x01 pc[15:8], 0x02 sp, 0x03 {o_ERROR,o_work_state}, others 0x00, pointer auto-increments.
REQ-018 SHALL, without DEBUG_I2C_EN, tie o_sda=1 and ignore i_scl/i_sda/i_debug_ena (no stall).

Verification
REQ-019 Reset -> state 00, o_instr_mem_wr_rdy=1, o_ERROR=000.
REQ-020 Load const 5, const 7, add, global.set 0, end; finish -> state 11; read 0x100 -> 12.
REQ-021 const 1, const -3, store, end -> read 0x001 -> 0xFFFFFFFD; const -8, const 1, shr_s, global.set 2 -> 0x102 -> -4.
REQ-022 g0=5, g1=1, loop g1*=g0, g0-=1, br_if on g0 -> 0x101 = 120, 0x100 = 0.
REQ-023 add on empty stack -> state 10, o_ERROR=001; opcode 0xFF -> o_ERROR=100.
REQ-024 DEBUG_I2C_EN, i_debug_ena=1 mid-EXEC, I2C read reg 0x02 at 0x6C -> current sp; pc frozen while enabled.

Source files
------------

// File: rtl/wasm_cpu_top.sv
// Small WebAssembly-subset stack CPU: host loads 64-bit instructions, the core executes them,
// the host reads globals/output memory. Define DEBUG_I2C_EN to add the I2C read-only debug slave.
`timescale 1ns/1ps
module wasm_cpu_top #(
    parameter int INSTR_DEPTH = 512,
    parameter int STACK_DEPTH = 16,
    parameter int OUT_DEPTH   = 256
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [2:0]  o_ERROR,
    output logic [1:0]  o_work_state,
    output logic        o_instr_mem_wr_rdy,
    input  logic        i_instr_mem_wr_vld,
    input  logic [14:0] i_instr_mem_wr_addr,
    input  logic [63:0] i_instr_mem_wr_data,
    input  logic        i_instr_mem_wr_finish,
    input  logic        i_line_mem_rd_rdy,
    input  logic [8:0]  i_line_mem_rd_addr,
    output logic [31:0] o_line_mem_rd_data,
    input  logic        i_scl,
    input  logic        i_sda,
    output logic        o_sda,
    input  logic        i_debug_ena
);
    localparam int GLOBAL_NUM = 16;
    localparam int IAW = $clog2(INSTR_DEPTH);
    localparam int SAW = $clog2(STACK_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);

    typedef enum logic [1:0] {ST_LOAD = 2'b00, ST_EXEC = 2'b01, ST_TRAP = 2'b10, ST_DONE = 2'b11} state_e;

    logic [63:0] imem_q    [INSTR_DEPTH];
    logic [31:0] stack_q   [STACK_DEPTH];
    logic [31:0] globals_q [GLOBAL_NUM];
    logic [31:0] out_mem_q [OUT_DEPTH];
    state_e      state_q;
    logic [31:0] pc_q;
    logic [SAW:0] sp_q;
    logic [2:0]  err_q;
    logic [31:0] rd_data_q;

    logic [63:0] instr_s;
    logic [7:0]  op_s;
    logic [31:0] imm_s, a_s, b_s, res_s, alu_s, ld_s;
    logic [SAW:0] sp_m1_s, sp_m2_s, sp_base_s, sp_next_s;
    logic [1:0]  npop_s;
    logic        npush_s, legal_s, stall_s;
    logic [2:0]  trap_s;

    assign instr_s   = imem_q[pc_q[IAW-1:0]];
    assign op_s      = instr_s[63:56];
    assign imm_s     = instr_s[31:0];
    assign sp_m1_s   = sp_q - (SAW+1)'(1);
    assign sp_m2_s   = sp_q - (SAW+1)'(2);
    assign b_s       = stack_q[sp_m1_s[SAW-1:0]];
    assign a_s       = stack_q[sp_m2_s[SAW-1:0]];
    assign sp_base_s = sp_q - (SAW+1)'(npop_s);
    assign sp_next_s = sp_base_s + (SAW+1)'(npush_s);

    assign o_ERROR            = err_q;
    assign o_work_state       = state_q;
    assign o_instr_mem_wr_rdy = (state_q == ST_LOAD);
    assign o_line_mem_rd_data = rd_data_q;

    // Binary ALU: b is the top of stack, a the entry below it
    always_comb begin
        alu_s = 32'd0;
        case (op_s)
            8'h46:   alu_s = {31'd0, a_s == b_s};
            8'h48:   alu_s = {31'd0, $signed(a_s) < $signed(b_s)};
            8'h6A:   alu_s = a_s + b_s;
            8'h6B:   alu_s = a_s - b_s;
            8'h6C:   alu_s = a_s * b_s;
            8'h71:   alu_s = a_s & b_s;
            8'h72:   alu_s = a_s | b_s;
            8'h73:   alu_s = a_s ^ b_s;
            8'h74:   alu_s = a_s << b_s[4:0];
            8'h75:   alu_s = $signed(a_s) >>> b_s[4:0];
            8'h76:   alu_s = a_s >> b_s[4:0];
            default: alu_s = 32'd0;
        endcase
    end

    // Load data path for i32.load
    always_comb begin
        ld_s = 32'd0;
        if ({24'd0, b_s[7:0]} < 32'(OUT_DEPTH)) begin
            ld_s = out_mem_q[b_s[OAW-1:0]];
        end else begin
            ld_s = 32'd0;
        end
    end

    // Decode: stack effect, legality and pushed value
    always_comb begin
        npop_s  = 2'd0;
        npush_s = 1'b0;
        legal_s = 1'b1;
        res_s   = 32'd0;
        case (op_s)
            8'h01, 8'h0B, 8'h0C: legal_s = 1'b1;
            8'h0D, 8'h1A, 8'h24: npop_s = 2'd1;
            8'h36: npop_s = 2'd2;
            8'h41: begin npush_s = 1'b1; res_s = imm_s; end
            8'h23: begin npush_s = 1'b1; res_s = globals_q[imm_s[3:0]]; end
            8'h28: begin npop_s = 2'd1; npush_s = 1'b1; res_s = ld_s; end
            8'h45: begin npop_s = 2'd1; npush_s = 1'b1; res_s = {31'd0, b_s == 32'd0}; end
            8'h46, 8'h48, 8'h6A, 8'h6B, 8'h6C, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h76: begin
                npop_s = 2'd2; npush_s = 1'b1; res_s = alu_s;
            end
            default: legal_s = 1'b0;
        endcase
    end

    // Trap priority: fetch range, reserved opcode, unknown opcode, underflow, overflow
    always_comb begin
        trap_s = 3'd0;
        if (pc_q >= 32'(INSTR_DEPTH))                                            trap_s = 3'd5;
        else if (op_s == 8'h00)                                                  trap_s = 3'd3;
        else if (!legal_s)                                                       trap_s = 3'd4;
        else if (sp_q < (SAW+1)'(npop_s))                                        trap_s = 3'd1;
        else if (npush_s && npop_s == 2'd0 && sp_q == (SAW+1)'(STACK_DEPTH))     trap_s = 3'd2;
        else                                                                     trap_s = 3'd0;
    end

    // Instruction memory write port, only open while loading; contents survive reset
    always_ff @(posedge i_clk) begin
        if (state_q == ST_LOAD && i_instr_mem_wr_vld) begin
            imem_q[i_instr_mem_wr_addr[IAW-1:0]] <= i_instr_mem_wr_data;
        end
    end

    // Control FSM with stack, globals and output memory updates
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_LOAD;
            pc_q    <= 32'd0;
            sp_q    <= '0;
            err_q   <= 3'd0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i]   <= 32'd0;
            for (int i = 0; i < GLOBAL_NUM; i++)  globals_q[i] <= 32'd0;
            for (int i = 0; i < OUT_DEPTH; i++)   out_mem_q[i] <= 32'd0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (i_instr_mem_wr_finish) begin
                        state_q <= ST_EXEC;
                        pc_q    <= 32'd0;
                        sp_q    <= '0;
                    end
                end
                ST_EXEC: begin
                    if (!stall_s) begin
                        if (trap_s != 3'd0) begin
                            state_q <= ST_TRAP;
                            err_q   <= trap_s;
                        end else begin
                            pc_q <= pc_q + 32'd1;
                            sp_q <= sp_next_s;
                            if (npush_s) stack_q[sp_base_s[SAW-1:0]] <= res_s;
                            case (op_s)
                                8'h0B: begin state_q <= ST_DONE; pc_q <= pc_q; end
                                8'h0C: pc_q <= imm_s;
                                8'h0D: if (b_s != 32'd0) pc_q <= imm_s;
                                8'h24: globals_q[imm_s[3:0]] <= b_s;
                                8'h36: if ({24'd0, a_s[7:0]} < 32'(OUT_DEPTH)) out_mem_q[a_s[OAW-1:0]] <= b_s;
                                default: ;
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Host read port: one-cycle latency, holds when not requested
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_data_q <= 32'd0;
        end else if (i_line_mem_rd_rdy) begin
            if (i_line_mem_rd_addr[8])
                rd_data_q <= globals_q[i_line_mem_rd_addr[3:0]];
            else if ({24'd0, i_line_mem_rd_addr[7:0]} < 32'(OUT_DEPTH))
                rd_data_q <= out_mem_q[i_line_mem_rd_addr[OAW-1:0]];
            else
                rd_data_q <= 32'd0;
        end
    end

`ifdef DEBUG_I2C_EN
    typedef enum logic [2:0] {I_IDLE, I_ADDR, I_ACK, I_WR, I_RD, I_RACK} i2c_e;
    i2c_e       i2c_q;
    logic [2:0] scl_q, sda_q;
    logic [3:0] cnt_q;
    logic [7:0] sh_q, tx_q, ptr_q, reg_s;
    logic       rw_q, more_q, sda_o_q;
    logic       scl_rise_s, scl_fall_s, start_s, stop_s, load_s;

    assign stall_s    = i_debug_ena;
    assign o_sda      = sda_o_q;
    assign scl_rise_s = scl_q[1] & ~scl_q[2];
    assign scl_fall_s = ~scl_q[1] & scl_q[2];
    assign start_s    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop_s     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
    assign load_s     = (i2c_q == I_ACK && rw_q) || (i2c_q == I_RACK && more_q);

    // Debug register file seen through the pointer
    always_comb begin
        reg_s = 8'd0;
        case (ptr_q)
            8'h00:   reg_s = pc_q[7:0];
            8'h01:   reg_s = pc_q[15:8];
            8'h02:   reg_s = 8'(sp_q);
            8'h03:   reg_s = {3'd0, err_q, state_q};
            default: reg_s = 8'd0;
        endcase
    end

    // I2C slave: synchronised bus, bits shifted on SCL rise, SDA changed on SCL fall
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            i2c_q <= I_IDLE; scl_q <= 3'b111; sda_q <= 3'b111; cnt_q <= 4'd0;
            sh_q <= 8'd0; tx_q <= 8'd0; ptr_q <= 8'd0; rw_q <= 1'b0; more_q <= 1'b0; sda_o_q <= 1'b1;
        end else begin
            scl_q <= {scl_q[1:0], i_scl};
            sda_q <= {sda_q[1:0], i_sda};
            if (!i_debug_ena || stop_s) begin
                i2c_q <= I_IDLE; sda_o_q <= 1'b1;
            end else if (start_s) begin
                i2c_q <= I_ADDR; cnt_q <= 4'd0; sda_o_q <= 1'b1;
            end else if (scl_rise_s) begin
                case (i2c_q)
                    I_ADDR, I_WR: begin sh_q <= {sh_q[6:0], sda_q[1]}; cnt_q <= cnt_q + 4'd1; end
                    I_RACK: if (sda_q[1]) i2c_q <= I_IDLE; else more_q <= 1'b1;
                    default: ;
                endcase
            end else if (scl_fall_s) begin
                if (load_s) begin
                    tx_q <= {reg_s[6:0], 1'b0}; sda_o_q <= reg_s[7]; ptr_q <= ptr_q + 8'd1;
                    cnt_q <= 4'd1; i2c_q <= I_RD;
                end else begin
                    case (i2c_q)
                        I_ADDR: if (cnt_q == 4'd8) begin
                            if (sh_q[7:1] == 7'h6C) begin sda_o_q <= 1'b0; rw_q <= sh_q[0]; i2c_q <= I_ACK; end
                            else i2c_q <= I_IDLE;
                        end
                        I_WR: if (cnt_q == 4'd8) begin
                            ptr_q <= sh_q; sda_o_q <= 1'b0; rw_q <= 1'b0; i2c_q <= I_ACK;
                        end
                        I_ACK: begin sda_o_q <= 1'b1; cnt_q <= 4'd0; i2c_q <= I_WR; end
                        I_RD: if (cnt_q == 4'd8) begin
                            sda_o_q <= 1'b1; more_q <= 1'b0; i2c_q <= I_RACK;
                        end else begin
                            sda_o_q <= tx_q[7]; tx_q <= {tx_q[6:0], 1'b0}; cnt_q <= cnt_q + 4'd1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    logic unused_s;
    assign unused_s = ^{instr_s[55:32], i_instr_mem_wr_addr[14:IAW]};
`else
    assign stall_s = 1'b0;
    assign o_sda   = 1'b1;

    logic unused_s;
    assign unused_s = ^{instr_s[55:32], i_instr_mem_wr_addr[14:IAW], i_scl, i_sda, i_debug_ena};
`endif
endmodule

// File: tb/tb_wasm_cpu_top.sv
// Directed bench for wasm_cpu_top: table of small programs with hand-computed results,
// plus sequences for memory retention, async reset mid-run, read-port hold and I2C debug.
`timescale 1ns/1ps
module tb_wasm_cpu_top;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  err;
    logic [1:0]  wst;
    logic        wr_rdy;
    logic        wr_vld = 1'b0;
    logic [14:0] wr_addr = 15'd0;
    logic [63:0] wr_data = 64'd0;
    logic        wr_fin = 1'b0;
    logic        rd_rdy = 1'b0;
    logic [8:0]  rd_addr = 9'd0;
    logic [31:0] rd_data;
    logic        scl_m = 1'b1, sda_m = 1'b1, sda_o, sda_bus, dbg = 1'b0;

    assign sda_bus = sda_m & sda_o;
    always #5 clk = ~clk;

    wasm_cpu_top dut (
        .i_clk(clk), .i_rst_n(rst_n), .o_ERROR(err), .o_work_state(wst),
        .o_instr_mem_wr_rdy(wr_rdy), .i_instr_mem_wr_vld(wr_vld), .i_instr_mem_wr_addr(wr_addr),
        .i_instr_mem_wr_data(wr_data), .i_instr_mem_wr_finish(wr_fin),
        .i_line_mem_rd_rdy(rd_rdy), .i_line_mem_rd_addr(rd_addr), .o_line_mem_rd_data(rd_data),
        .i_scl(scl_m), .i_sda(sda_bus), .o_sda(sda_o), .i_debug_ena(dbg)
    );

    typedef struct {
        int          start;
        int          n;
        logic [8:0]  addr;
        logic [1:0]  st;
        logic [2:0]  er;
        logic [31:0] rd;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] rom [256];
    int          k = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic emit(input logic [7:0] op, input logic [31:0] imm);
        rom[k] = {op, 24'd0, imm};
        k++;
    endtask

    task automatic add_vec(input int s, input logic [8:0] a, input logic [1:0] st,
                           input logic [2:0] e, input logic [31:0] rd);
        vec_t v;
        v.start = s; v.n = k - s; v.addr = a; v.st = st; v.er = e; v.rd = rd;
        vecs.push_back(v);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0; wr_vld = 1'b0; wr_fin = 1'b0; rd_rdy = 1'b0; dbg = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk({tag, "_rst_state"}, 32'(wst), 32'd0);
        chk({tag, "_rst_rdy"}, 32'(wr_rdy), 32'd1);
        chk({tag, "_rst_err"}, 32'(err), 32'd0);
        chk({tag, "_rst_rdata"}, rd_data, 32'd0);
    endtask

    task automatic load(input int s, input int n);
        for (int i = 0; i < n; i++) begin
            wr_vld = 1'b1; wr_addr = 15'(i); wr_data = rom[s + i]; wr_fin = (i == n - 1);
            @(negedge clk);
        end
        if (n == 0) begin
            wr_fin = 1'b1;
            @(negedge clk);
        end
        wr_vld = 1'b0; wr_fin = 1'b0;
    endtask

    task automatic run_wait();
        for (int i = 0; i < 3000; i++) begin
            if (wst != 2'b01) break;
            @(negedge clk);
        end
    endtask

    task automatic read_line(input logic [8:0] a, output logic [31:0] d);
        rd_rdy = 1'b1; rd_addr = a;
        @(negedge clk);
        rd_rdy = 1'b0;
        d = rd_data;
    endtask

`ifdef DEBUG_I2C_EN
    task automatic i2c_wait(); repeat (8) @(posedge clk); endtask
    task automatic i2c_start(); sda_m = 1'b1; scl_m = 1'b1; i2c_wait(); sda_m = 1'b0; i2c_wait(); scl_m = 1'b0; i2c_wait(); endtask
    task automatic i2c_stop(); sda_m = 1'b0; i2c_wait(); scl_m = 1'b1; i2c_wait(); sda_m = 1'b1; i2c_wait(); endtask
    task automatic i2c_bit(input logic b, output logic r);
        sda_m = b; i2c_wait(); scl_m = 1'b1; i2c_wait(); r = sda_bus; scl_m = 1'b0; i2c_wait();
    endtask
    task automatic i2c_wr(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
        i2c_bit(1'b1, ack);
    endtask
    task automatic i2c_rd(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin i2c_bit(1'b1, r); d[i] = r; end
        i2c_bit(nack, r);
    endtask
    task automatic i2c_dump(output logic [7:0] b0, b1, b2, b3, output logic [1:0] acks);
        logic a0, a1, a2;
        i2c_start(); i2c_wr(8'hD8, a0); i2c_wr(8'h00, a1); i2c_stop();
        i2c_start(); i2c_wr(8'hD9, a2);
        i2c_rd(1'b0, b0); i2c_rd(1'b0, b1); i2c_rd(1'b0, b2); i2c_rd(1'b1, b3);
        i2c_stop();
        acks = {a0 | a1, a2};
    endtask
`endif

    initial begin
        #900000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1);
    end

    initial begin
        int s;
        logic [31:0] d;
        rst_n = 1'b0;

        // 0: 5 + 7 into g0
        s = k; emit(8'h41, 5); emit(8'h41, 7); emit(8'h6A, 0); emit(8'h24, 0); emit(8'h0B, 0);
        add_vec(s, 9'h100, 2'b11, 3'd0, 32'd12);
        // 1: store -3 at out_mem[1]
        s = k; emit(8'h41, 1); emit(8'h41, 32'hFFFF_FFFD); emit(8'h36, 0); emit(8'h0B, 0);
        add_vec(s, 9'h001, 2'b11, 3'd0, 32'hFFFF_FFFD);
        // 2: -8 >>> 1 into g2
        s = k; emit(8'h41, 32'hFFFF_FFF8); emit(8'h41, 1); emit(8'h75, 0); emit(8'h24, 2); emit(8'h0B, 0);
        add_vec(s, 9'h102, 2'b11, 3'd0, 32'hFFFF_FFFC);
        // 3,4: factorial loop
        s = k;
        emit(8'h41, 5); emit(8'h24, 0); emit(8'h41, 1); emit(8'h24, 1);
        emit(8'h23, 1); emit(8'h23, 0); emit(8'h6C, 0); emit(8'h24, 1);
        emit(8'h23, 0); emit(8'h41, 1); emit(8'h6B, 0); emit(8'h24, 0);
        emit(8'h23, 0); emit(8'h0D, 4); emit(8'h0B, 0);
        add_vec(s, 9'h101, 2'b11, 3'd0, 32'd120);
        add_vec(s, 9'h100, 2'b11, 3'd0, 32'd0);
        // 5..8: traps
        s = k; emit(8'h6A, 0); add_vec(s, 9'h100, 2'b10, 3'd1, 32'd0);
        s = k; emit(8'hFF, 0); add_vec(s, 9'h100, 2'b10, 3'd4, 32'd0);
        s = k; emit(8'h00, 0); add_vec(s, 9'h100, 2'b10, 3'd3, 32'd0);
        s = k; emit(8'h0C, 600); add_vec(s, 9'h100, 2'b10, 3'd5, 32'd0);
        // 9: compares
        s = k; emit(8'h41, 3); emit(8'h41, 3); emit(8'h46, 0); emit(8'h41, 32'hFFFF_FFFF); emit(8'h41, 2);
        emit(8'h48, 0); emit(8'h6A, 0); emit(8'h24, 3); emit(8'h0B, 0);
        add_vec(s, 9'h103, 2'b11, 3'd0, 32'd2);
        // 10: shifts and logic
        s = k; emit(8'h41, 32'hF0); emit(8'h41, 4); emit(8'h76, 0); emit(8'h41, 1); emit(8'h41, 35);
        emit(8'h74, 0); emit(8'h72, 0); emit(8'h41, 6); emit(8'h71, 0); emit(8'h41, 0); emit(8'h45, 0);
        emit(8'h73, 0); emit(8'h24, 4); emit(8'h0B, 0);
        add_vec(s, 9'h104, 2'b11, 3'd0, 32'd7);
        // 11: store then load back
        s = k; emit(8'h41, 9); emit(8'h41, 32'h1234); emit(8'h36, 0); emit(8'h41, 9); emit(8'h28, 0);
        emit(8'h41, 1); emit(8'h6A, 0); emit(8'h24, 6); emit(8'h0B, 0);
        add_vec(s, 9'h106, 2'b11, 3'd0, 32'h1235);
        // 12: wrap-around mul/add
        s = k; emit(8'h41, 32'h10001); emit(8'h41, 32'h10001); emit(8'h6C, 0); emit(8'h41, 32'h7FFF_FFFF);
        emit(8'h6A, 0); emit(8'h24, 8); emit(8'h01, 0); emit(8'h0B, 0);
        add_vec(s, 9'h108, 2'b11, 3'd0, 32'h8002_0000);
        // 13: br_if not taken on zero; 14: drop on empty stack
        s = k; emit(8'h41, 0); emit(8'h0D, 4); emit(8'h41, 1); emit(8'h24, 10); emit(8'h0B, 0);
        add_vec(s, 9'h10A, 2'b11, 3'd0, 32'd1);
        s = k; emit(8'h1A, 0); add_vec(s, 9'h100, 2'b10, 3'd1, 32'd0);
        // 15: exactly full stack is fine; 16: one more push overflows
        s = k; for (int i = 0; i < 16; i++) emit(8'h41, 32'(i)); emit(8'h0B, 0);
        add_vec(s, 9'h100, 2'b11, 3'd0, 32'd0);
        s = k; for (int i = 0; i < 17; i++) emit(8'h41, 32'(i));
        add_vec(s, 9'h100, 2'b10, 3'd2, 32'd0);

        foreach (vecs[i]) begin
            do_reset($sformatf("v%0d", i));
            load(vecs[i].start, vecs[i].n);
            run_wait();
            chk($sformatf("v%0d_state", i), 32'(wst), 32'(vecs[i].st));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].er));
            chk($sformatf("v%0d_rdy", i), 32'(wr_rdy), 32'd0);
            read_line(vecs[i].addr, d);
            chk($sformatf("v%0d_rdata", i), d, vecs[i].rd);
        end

        // Writes after LOAD are ignored and program memory survives reset
        do_reset("keep");
        load(vecs[0].start, vecs[0].n);
        run_wait();
        wr_vld = 1'b1; wr_addr = 15'd0; wr_data = {8'hFF, 56'd0}; wr_fin = 1'b1;
        @(negedge clk);
        wr_vld = 1'b0; wr_fin = 1'b0;
        repeat (10) @(negedge clk);
        chk("done_hold_state", 32'(wst), 32'd3);
        chk("done_hold_err", 32'(err), 32'd0);
        do_reset("keep2");
        load(0, 0);
        run_wait();
        chk("keep_state", 32'(wst), 32'd3);
        read_line(9'h100, d);
        chk("keep_rdata", d, 32'd12);
        rd_addr = 9'h101;
        @(negedge clk);
        chk("rd_hold", rd_data, 32'd12);

        // Async reset in the middle of an endless loop
        s = k; emit(8'h0C, 0);
        do_reset("midrun");
        load(s, 1);
        repeat (20) @(negedge clk);
        chk("loop_state", 32'(wst), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(wst), 32'd0);
        chk("async_rst_rdy", 32'(wr_rdy), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef DEBUG_I2C_EN
        begin
            logic [7:0] p0, p1, sp, stt, q0, q1, sq, qt;
            logic [1:0] ak, ak2;
            s = k; emit(8'h41, 1); emit(8'h1A, 0); emit(8'h0C, 0);
            do_reset("i2c");
            load(s, 3);
            repeat (7) @(negedge clk);
            dbg = 1'b1;
            repeat (4) @(negedge clk);
            i2c_dump(p0, p1, sp, stt, ak);
            i2c_dump(q0, q1, sq, qt, ak2);
            chk("i2c_acks", 32'(ak), 32'd0);
            chk("i2c_pc_hi", 32'(p1), 32'd0);
            chk("i2c_status", 32'(stt), 32'h01);
            chk("i2c_pc_range", 32'(p0 < 8'd3), 32'd1);
            chk("i2c_sp", 32'(sp), (p0 == 8'd1) ? 32'd1 : 32'd0);
            chk("i2c_pc_frozen", 32'(q0), 32'(p0));
            chk("i2c_sp_frozen", 32'(sq), 32'(sp));
            chk("i2c_state", 32'(wst), 32'd1);
            dbg = 1'b0;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
